// File: rtl/bitonic_merge_pipe.sv
// bitonic_merge_pipe: pipelined runtime-direction bitonic merger with valid/ready and bubble collapsing
package muon_pkg;
  typedef struct packed {
    logic [8:0] pt;
    logic [7:0] eta;
    logic [5:0] phi;
    logic       chg;
  } muon_t;
endpackage

module bitonic_merge_pipe #(
  parameter int WIDTH     = 8,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_dir,
  input  logic [TAG_W-1:0]                  in_tag,
  input  muon_pkg::muon_t [0:WIDTH-1]       m,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_dir,
  output logic [TAG_W-1:0]                  out_tag,
  output muon_pkg::muon_t [0:WIDTH-1]       q
);
  localparam int NSTAGE = $clog2(WIDTH);
  typedef muon_pkg::muon_t [0:WIDTH-1] vec_t;
  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("WIDTH must be a power of two >= 2");
  end
  if (REG_EVERY < 1 || REG_EVERY > NSTAGE) begin : g_bad_reg_every
    $error("REG_EVERY must be in 1..log2(WIDTH)");
  end
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("TAG_W must be >= 1");
  end
  vec_t             a   [0:NSTAGE];
  logic             v   [0:NSTAGE];
  logic             d   [0:NSTAGE];
  logic [TAG_W-1:0] t   [0:NSTAGE];
  logic             rdy [0:NSTAGE];
  assign a[0]        = m;
  assign v[0]        = in_valid;
  assign d[0]        = in_dir;
  assign t[0]        = in_tag;
  assign rdy[NSTAGE] = out_ready;
  assign in_ready    = rdy[0];
  assign q           = a[NSTAGE];
  assign out_valid   = v[NSTAGE];
  assign out_dir     = d[NSTAGE];
  assign out_tag     = t[NSTAGE];
  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    localparam int H = WIDTH >> (s + 1);
    vec_t c;
    for (genvar p = 0; p < WIDTH / 2; p++) begin : g_pair
      localparam int I = (p / H) * 2 * H + p % H;
      logic sw;
      assign sw       = d[s] ? (a[s][I].pt < a[s][I+H].pt) : (a[s][I].pt > a[s][I+H].pt);
      assign c[I]     = sw ? a[s][I+H] : a[s][I];
      assign c[I+H]   = sw ? a[s][I]   : a[s][I+H];
    end
    if ((s + 1) % REG_EVERY == 0 || s == NSTAGE - 1) begin : g_reg
      vec_t             data_q, data_d;
      logic             v_q, v_d, dir_q, dir_d;
      logic [TAG_W-1:0] tag_q, tag_d;
      logic             ld;
      assign ld = rdy[s] && v[s];
      always_comb begin
        v_d    = rdy[s] ? v[s] : v_q;
        data_d = ld ? c : data_q;
        dir_d  = ld ? d[s] : dir_q;
        tag_d  = ld ? t[s] : tag_q;
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q    <= 1'b0;
          data_q <= '0;
          dir_q  <= 1'b0;
          tag_q  <= '0;
        end else begin
          v_q    <= v_d;
          data_q <= data_d;
          dir_q  <= dir_d;
          tag_q  <= tag_d;
        end
      end
      assign rdy[s]   = !v_q || rdy[s+1];
      assign a[s+1]   = data_q;
      assign v[s+1]   = v_q;
      assign d[s+1]   = dir_q;
      assign t[s+1]   = tag_q;
    end else begin : g_comb
      assign rdy[s]   = rdy[s+1];
      assign a[s+1]   = c;
      assign v[s+1]   = v[s];
      assign d[s+1]   = d[s];
      assign t[s+1]   = t[s];
    end
  end
endmodule

// File: tb/tb_bitonic_merge_pipe.sv
// tb_bitonic_merge_pipe: directed and random checks of the pipelined bitonic merger against a sort-based model
module tb_bitonic_merge_pipe;
  typedef struct packed {
    logic [143:0] pts;
    logic [383:0] set;
    logic         dir;
    logic [7:0]   tag;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic iv8, ir8, dir8, ov8, ordy8, od8;
  logic [7:0] tag8, ot8;
  muon_pkg::muon_t [0:7] m8, q8;
  logic iv16, ir16, dir16, ov16, ordy16, od16;
  logic [7:0] tag16, ot16;
  muon_pkg::muon_t [0:15] m16, q16;
  int nchk = 0;
  int nerr = 0;
  int nout8 = 0;
  exp_t sb8[$];
  exp_t sb16[$];
  always #5 clk = ~clk;
  bitonic_merge_pipe #(.WIDTH(8), .REG_EVERY(1), .TAG_W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_dir(dir8), .in_tag(tag8), .m(m8),
    .out_valid(ov8), .out_ready(ordy8), .out_dir(od8), .out_tag(ot8), .q(q8));
  bitonic_merge_pipe #(.WIDTH(16), .REG_EVERY(2), .TAG_W(8)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_dir(dir16), .in_tag(tag16), .m(m16),
    .out_valid(ov16), .out_ready(ordy16), .out_dir(od16), .out_tag(ot16), .q(q16));

  task automatic chk(input string nm, input logic [383:0] o, input logic [383:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", nm, o, e);
    end
  endtask

  function automatic logic [143:0] pts_of(input logic [383:0] v, input int n, input int mode);
    int a[$];
    logic [143:0] r = '0;
    for (int i = 0; i < n; i++) a.push_back(int'(v[(n-1-i)*24+15 +: 9]));
    if (mode == 1) a.rsort();
    if (mode == 0) a.sort();
    for (int i = 0; i < n; i++) r[i*9 +: 9] = 9'(a[i]);
    return r;
  endfunction

  function automatic logic [383:0] set_of(input logic [383:0] v, input int n);
    int a[$];
    logic [383:0] r = '0;
    for (int i = 0; i < n; i++) a.push_back(int'(v[(n-1-i)*24 +: 24]));
    a.sort();
    for (int i = 0; i < n; i++) r[i*24 +: 24] = 24'(a[i]);
    return r;
  endfunction

  task automatic gen(input int n, output logic [383:0] v);
    int vals[$];
    int l[$];
    int r[$];
    int s[$];
    int rot;
    int hi;
    hi = ($urandom % 2) ? 15 : 511;
    for (int i = 0; i < n; i++) vals.push_back(int'($urandom_range(0, hi)));
    vals.sort();
    foreach (vals[i]) if ($urandom % 2) l.push_back(vals[i]); else r.push_front(vals[i]);
    s = {l, r};
    rot = int'($urandom_range(0, n - 1));
    v = '0;
    for (int i = 0; i < n; i++) v[(n-1-i)*24 +: 24] = {9'(s[(i+rot)%n]), 15'($urandom)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t b;
    if (!rst) begin
      if (ov8 && ordy8) begin
        chk("sb8_nonempty", 384'(sb8.size() > 0), 384'(1));
        if (sb8.size() > 0) begin
          b = sb8.pop_front();
          chk("pt8", pts_of({192'b0, q8}, 8, 2), b.pts);
          chk("set8", set_of({192'b0, q8}, 8), b.set);
          chk("dir8", od8, b.dir);
          chk("tag8", ot8, b.tag);
        end
        nout8++;
      end
      if (iv8 && ir8) sb8.push_back('{pts: pts_of({192'b0, m8}, 8, dir8 ? 1 : 0), set: set_of({192'b0, m8}, 8), dir: dir8, tag: tag8});
      if (ov16 && ordy16) begin
        chk("sb16_nonempty", 384'(sb16.size() > 0), 384'(1));
        if (sb16.size() > 0) begin
          b = sb16.pop_front();
          chk("pt16", pts_of(q16, 16, 2), b.pts);
          chk("set16", set_of(q16, 16), b.set);
          chk("dir16", od16, b.dir);
          chk("tag16", ot16, b.tag);
        end
      end
      if (iv16 && ir16) sb16.push_back('{pts: pts_of(m16, 16, dir16 ? 1 : 0), set: set_of(m16, 16), dir: dir16, tag: tag16});
    end
  end

  initial begin
    logic [383:0] v;
    logic [143:0] desc, asc;
    logic [191:0] qs;
    logic [7:0] ts;
    int p1[8] = '{1, 3, 5, 7, 6, 4, 2, 0};
    int n0;
    desc = '0;
    asc = '0;
    for (int i = 0; i < 8; i++) begin
      desc[i*9 +: 9] = 9'(7 - i);
      asc[i*9 +: 9]  = 9'(i);
    end
    rst = 1'b1;
    iv8 = 1'b0; dir8 = 1'b0; tag8 = '0; m8 = '0; ordy8 = 1'b1;
    iv16 = 1'b0; dir16 = 1'b0; tag16 = '0; m16 = '0; ordy16 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ov", ov8, 0);
    chk("rst_q", q8, 0);
    chk("rst_dir", od8, 0);
    chk("rst_tag", ot8, 0);
    chk("rst_ir", ir8, 1);
    chk("rst_ir16", ir16, 1);
    for (int i = 0; i < 8; i++) m8[i] = {9'(p1[i]), 8'(i + 16), 6'(i), 1'(i)};
    dir8 = 1'b1;
    tag8 = 8'hA5;
    iv8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) iv8 = 1'b0;
      chk("lat8_valid", ov8, 384'(k == 3));
      if (k == 3) begin
        chk("lat8_q", pts_of({192'b0, q8}, 8, 2), desc);
        chk("lat8_tag", ot8, 8'hA5);
        chk("lat8_dir", od8, 1);
      end
    end
    for (int k = 1; k <= 7; k++) begin
      iv8 = (k <= 4);
      dir8 = (k % 2 == 1);
      tag8 = 8'(k - 1);
      tick();
      chk("b2b_valid", ov8, 384'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) begin
        chk("b2b_tag", ot8, 384'(k - 3));
        chk("b2b_dir", od8, 384'((k - 3) % 2 == 0));
        chk("b2b_q", pts_of({192'b0, q8}, 8, 2), ((k - 3) % 2 == 0) ? desc : asc);
      end
    end
    iv8 = 1'b0;
    n0 = nout8;
    ordy8 = 1'b0;
    iv8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gen(8, v);
      m8 = v[191:0];
      tag8 = 8'(16 + k);
      dir8 = 1'($urandom);
      chk("bp_ir_open", ir8, 1);
      tick();
    end
    gen(8, v);
    m8 = v[191:0];
    tag8 = 8'd19;
    qs = q8;
    ts = ot8;
    for (int k = 0; k < 5; k++) begin
      chk("bp_ir_full", ir8, 0);
      chk("bp_ov", ov8, 1);
      chk("bp_q_stable", q8, qs);
      chk("bp_tag_stable", ot8, ts);
      tick();
    end
    ordy8 = 1'b1;
    #1;
    chk("bp_ir_pass", ir8, 1);
    tick();
    iv8 = 1'b0;
    repeat (6) tick();
    chk("bp_drained", sb8.size(), 0);
    chk("bp_count", nout8 - n0, 4);
    for (int dd = 0; dd < 2; dd++) begin
      for (int i = 0; i < 8; i++) m8[i] = {9'd4, 8'(i * 3 + 1), 6'(i + 40), 1'(i)};
      dir8 = 1'(dd);
      iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      tick();
      tick();
      chk("eq_valid", ov8, 1);
      chk("eq_q", q8, m8);
      tick();
    end
    iv8 = 1'b1;
    gen(8, v);
    m8 = v[191:0];
    tick();
    gen(8, v);
    m8 = v[191:0];
    tick();
    iv8 = 1'b0;
    rst = 1'b1;
    sb8.delete();
    sb16.delete();
    tick();
    rst = 1'b0;
    chk("mid_rst_ov", ov8, 0);
    chk("mid_rst_q", q8, 0);
    chk("mid_rst_tag", ot8, 0);
    chk("mid_rst_dir", od8, 0);
    gen(8, v);
    m8 = v[191:0];
    tag8 = 8'h77;
    iv8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) iv8 = 1'b0;
      chk("mid_rst_lat", ov8, 384'(k == 3));
    end
    gen(16, v);
    m16 = v;
    tag16 = 8'h3C;
    dir16 = 1'b1;
    iv16 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) iv16 = 1'b0;
      chk("lat16_valid", ov16, 384'(k == 2));
    end
    for (int k = 0; k < 2000; k++) begin
      gen(8, v);
      m8 = v[191:0];
      iv8 = ($urandom % 4 != 0);
      ordy8 = ($urandom % 4 != 0);
      dir8 = 1'($urandom);
      tag8 = 8'($urandom);
      gen(16, v);
      m16 = v;
      iv16 = ($urandom % 4 != 0);
      ordy16 = ($urandom % 4 != 0);
      dir16 = 1'($urandom);
      tag16 = 8'($urandom);
      tick();
    end
    iv8 = 1'b0;
    iv16 = 1'b0;
    ordy8 = 1'b1;
    ordy16 = 1'b1;
    repeat (8) tick();
    chk("rand8_drained", sb8.size(), 0);
    chk("rand16_drained", sb16.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/bitonic_merge_pipe.md
# bitonic_merge_pipe

Pipelined, runtime-direction bitonic merger for the muon sorting network. Accepts one bitonic sequence of `WIDTH` `muon_t` candidates per beat and emits it fully sorted after a fixed number of register stages. Valid/ready flow control with bubble collapsing, so it can sit between a FIFO and the downstream sorter stages without a global stall. Replaces the purely combinational merger wherever the compare depth no longer closes timing in one cycle.

## Interface
- `WIDTH`, 8: candidates per beat; power of two, >= 2; any other value is an elaboration error.
- `REG_EVERY`, 1: compare stages between pipeline registers; 1..log2(WIDTH).
- `TAG_W`, 8: width of the opaque sideband tag carried alongside each beat; >= 1.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the input beat this cycle.
- `in_dir`  in  1  per-beat order: 1 = descending (largest `pt` at index 0), 0 = ascending.
- `in_tag`  in  TAG_W  sideband, returned unchanged with the beat.
- `m`  in  muon_t [0:WIDTH-1]  bitonic input sequence.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  downstream accepts the output beat.
- `out_dir`  out  1  direction the beat was sorted with.
- `out_tag`  out  TAG_W  tag of the output beat.
- `q`  out  muon_t [0:WIDTH-1]  sorted sequence.

## Operation
- NSTAGE = log2(WIDTH) compare stages. Stage s (s = 0..NSTAGE-1) compares element i with i + WIDTH/2^(s+1) within each block of WIDTH/2^s elements (standard half-cleaner recursion).
- Key is `muon_t.pt`, unsigned. dir=1: larger key to lower index; dir=0: smaller key to lower index. Equal keys: no exchange. Non-key fields move with their key.
- `dir` and `tag` travel with the beat through every register; each beat is sorted with its own captured `dir`, so consecutive beats may alternate direction.
- Pipeline register after compare stage s when (s+1) % REG_EVERY == 0 or s == NSTAGE-1. Output is always registered. Register count L = ceil(NSTAGE / REG_EVERY).
- Each register stage r holds `v_r`, data, dir, tag. Stage r loads when `ready_r = !v_r || ready_(r+1)`; `ready_L = out_ready`; `in_ready = ready_1`. On load, `v_r` takes the upstream valid (bubbles are overwritten, not held).
- Stage contents unchanged while `v_r` = 1 and `ready_(r+1)` = 0 (back-pressure holds data stable, including `q`, `out_dir`, `out_tag`).
- Input `m` is not checked for bitonicity; non-bitonic input gives a deterministic but unspecified permutation, never loss or duplication of elements.
- Reset: all `v_r` = 0, all data/dir/tag registers = 0. Reset mid-operation discards every in-flight beat; nothing is emitted for them.

## Timing
- Reset values: `out_valid` = 0, `q` = all-zero `muon_t`, `out_dir` = 0, `out_tag` = 0; `in_ready` = 1 in the first cycle after reset release.
- Latency: beat accepted at edge n (in_valid & in_ready) appears with `out_valid` = 1 in the cycle after edge n+L-1, i.e. visible L cycles later, when no back-pressure.
- Throughput: one beat per cycle with `out_ready` held 1.
- `in_ready` is combinational from `out_ready` and the valid bits; no combinational path from `in_valid` or `m` to `in_ready`.
- Simultaneous accept and emit in the same cycle is allowed when full; full pipeline with `out_ready` = 0 forces `in_ready` = 0.
- `rst` has priority over any handshake in the same cycle.

## Test plan
- WIDTH=8, REG_EVERY=1, dir=1, pt = {1,3,5,7,6,4,2,0}, out_ready=1 -> after 3 cycles q.pt = {7,6,5,4,3,2,1,0}, out_tag equals in_tag, out_valid high one cycle.
- Same input back-to-back with alternating dir (1,0,1,0), tags 0..3 -> four consecutive output beats, descending/ascending alternately, tags 0,1,2,3 in order, no gaps.
- WIDTH=16, REG_EVERY=2 -> latency 2; REG_EVERY=4 -> latency 1; results bit-identical to a reference model for 10k random bitonic inputs.
- Fill pipeline, hold out_ready=0 for 5 cycles -> in_ready=0 once L beats held, q/out_tag stable; release -> beats drain in order, none lost or duplicated.
- Equal keys: pt all 4 with distinct other fields -> q identical to m for both dir values.
- Assert rst for one cycle with 2 beats in flight -> out_valid=0 next cycle, all outputs zero, next accepted beat emerges after exactly L cycles.
